// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Includes the FSM state enum and the 3-sample vote helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam int OVERSAMPLE_DEF = 16;

  function automatic int vote_first(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int vote_mid(input int os);
    return os / 2;
  endfunction

  function automatic int vote_last(input int os);
    return os / 2 + 1;
  endfunction

  function automatic logic maj3(input logic a,
                                input logic b,
                                input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Parallel side of the receiver: RX FIFO write port and status.
// master = deserializer, slave = FIFO / status consumer.
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 fifo_full;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_error;
  logic                 frame_error;
  logic                 overrun_error;
  logic                 rx_busy;

  modport master (
    input  fifo_full,
    output rx_data,
    output rx_valid,
    output parity_error,
    output frame_error,
    output overrun_error,
    output rx_busy
  );

  modport slave (
    output fifo_full,
    input  rx_data,
    input  rx_valid,
    input  parity_error,
    input  frame_error,
    input  overrun_error,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Pin synchronizer plus 3-sample majority vote around mid-bit.
// vote is meaningful on the baud_tick where tcnt is the last vote tick.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int TW         = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx_pin,
  input  logic          baud_tick,
  input  logic [TW-1:0] tcnt,
  output logic          rxs,
  output logic          vote
);

  localparam logic [TW-1:0] T_V0 = TW'(vote_first(OVERSAMPLE));
  localparam logic [TW-1:0] T_V1 = TW'(vote_mid(OVERSAMPLE));

  logic [1:0] sync_q, sync_d;
  logic [1:0] smp_q, smp_d;

  assign rxs  = sync_q[1];
  assign vote = maj3(smp_q[0], smp_q[1], rxs);

  // Next synchronizer stage and captured early vote samples
  always_comb begin
    sync_d = {sync_q[0], rx_pin};
    smp_d  = smp_q;
    if (baud_tick && tcnt == T_V0) smp_d[0] = rxs;
    if (baud_tick && tcnt == T_V1) smp_d[1] = rxs;
  end

  // Sampler state; line idles high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      smp_q  <= 2'b11;
    end else begin
      sync_q <= sync_d;
      smp_q  <= smp_d;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive bit engine: framing FSM, shift register and
// one-cycle FIFO write / error strobes.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_pin,
  input  logic baud_tick,
  uart_rx_deserializer_if.master rx_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_VOTE = TW'(vote_last(OVERSAMPLE));
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  state_t                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   valid_q, valid_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   oe_q, oe_d;
  logic                   rxs, vote;
  logic                   at_vote, at_last;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE),
    .TW        (TW)
  ) u_sampler (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_pin   (rx_pin),
    .baud_tick(baud_tick),
    .tcnt     (tcnt_q),
    .rxs      (rxs),
    .vote     (vote)
  );

  assign at_vote = (tcnt_q == T_VOTE);
  assign at_last = (tcnt_q == T_LAST);

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.parity_error  = pe_q;
  assign rx_if.frame_error   = fe_q;
  assign rx_if.overrun_error = oe_q;
  assign rx_if.rx_busy       = (state_q != IDLE);

  // Frame FSM: advances only on baud_tick, strobes default low
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    perr_d  = perr_q;
    valid_d = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    oe_d    = 1'b0;
    if (baud_tick) begin
      tcnt_d = at_last ? '0 : tcnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          tcnt_d = '0;
          if (!rxs) begin
            state_d = START;
            bcnt_d  = '0;
            perr_d  = 1'b0;
          end
        end
        START: begin
          if (at_vote && vote) state_d = IDLE;
          else if (at_last)    state_d = DATA;
        end
        DATA: begin
          if (at_vote) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (at_last) begin
            if (bcnt_q == B_LAST) begin
              bcnt_d  = '0;
              state_d = PARITY_EN ? PARITY : STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_vote) perr_d = vote ^ (^shreg_q) ^ PARITY_ODD;
          if (at_last) state_d = STOP;
        end
        STOP: begin
          if (at_vote) begin
            if (!vote) begin
              fe_d    = 1'b1;
              state_d = BREAK;
            end else if (rx_if.fifo_full) begin
              oe_d    = 1'b1;
              state_d = IDLE;
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              pe_d    = perr_q;
              state_d = IDLE;
            end
          end
        end
        BREAK: begin
          tcnt_d = '0;
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, datapath and strobe registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench: 8N1 instance and 8E1 instance,
// frame driver plus strobe monitor feeding a scoreboard.
module tb_uart_rx_deserializer;

  localparam int TICK_CLKS = 27;
  localparam int BIT_CLKS  = 16 * TICK_CLKS;

  typedef struct {
    logic [7:0] d;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic baud_tick = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  int   tick_cnt = 0;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   nv0 = 0, nfe0 = 0, noe0 = 0, npe0 = 0;
  int   nv1 = 0, nfe1 = 0, noe1 = 0, npe1 = 0;

  uart_rx_deserializer_if #(.DATA_BITS(8)) if0 ();
  uart_rx_deserializer_if #(.DATA_BITS(8)) if1 ();

  uart_rx_deserializer #(
    .DATA_BITS(8), .OVERSAMPLE(16),
    .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .rx_pin(rx0),
    .baud_tick(baud_tick), .rx_if(if0)
  );

  uart_rx_deserializer #(
    .DATA_BITS(8), .OVERSAMPLE(16),
    .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .rx_pin(rx1),
    .baud_tick(baud_tick), .rx_if(if1)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (tick_cnt == TICK_CLKS - 1) begin
      tick_cnt  <= 0;
      baud_tick <= 1'b1;
    end else begin
      tick_cnt  <= tick_cnt + 1;
      baud_tick <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor and scoreboard pop
  always @(negedge clk) begin
    exp_t e;
    if (if0.rx_valid) begin
      nv0++;
      if (if0.parity_error) npe0++;
      if (q0.size() == 0) chk("u0_unexp_valid", 1, 0);
      else begin
        e = q0.pop_front();
        chk("u0_data", {24'd0, if0.rx_data}, {24'd0, e.d});
        chk("u0_perr", {31'd0, if0.parity_error}, {31'd0, e.pe});
      end
    end
    if (if0.frame_error) nfe0++;
    if (if0.overrun_error) noe0++;
    if (if1.rx_valid) begin
      nv1++;
      if (if1.parity_error) npe1++;
      if (q1.size() == 0) chk("u1_unexp_valid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("u1_data", {24'd0, if1.rx_data}, {24'd0, e.d});
        chk("u1_perr", {31'd0, if1.parity_error}, {31'd0, e.pe});
      end
    end
    if (if1.frame_error) nfe1++;
    if (if1.overrun_error) noe1++;
  end

  task automatic drive_bit(input int inst, input logic v);
    if (inst == 0) rx0 = v;
    else           rx1 = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send(input int inst, input logic [7:0] d,
                      input bit par_en, input logic par,
                      input logic stop);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(inst, d[i]);
    if (par_en) drive_bit(inst, par);
    drive_bit(inst, stop);
  endtask

  initial begin
    int c;
    int v0, fe0, oe0;
    if0.fifo_full = 1'b0;
    if1.fifo_full = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", {31'd0, if0.rx_valid}, 0);
    chk("rst_data",  {24'd0, if0.rx_data}, 0);
    chk("rst_busy",  {31'd0, if0.rx_busy}, 0);
    chk("rst_flags", {29'd0, if0.frame_error,
         if0.overrun_error, if0.parity_error}, 0);
    reset_n = 1'b1;
    repeat (2 * TICK_CLKS) @(negedge clk);

    // T1 clean 8N1 frames
    begin
      logic [7:0] t1 [5];
      t1 = '{8'h55, 8'h4E, 8'hF0, 8'hFF, 8'h00};
      foreach (t1[i]) begin
        q0.push_back('{d: t1[i], pe: 1'b0});
        send(0, t1[i], 1'b0, 1'b0, 1'b1);
      end
    end
    drive_bit(0, 1'b1);
    chk("t1_nvalid", nv0, 5);
    chk("t1_nerr", nfe0 + noe0 + npe0, 0);
    chk("t1_q_empty", q0.size(), 0);
    chk("t1_busy", {31'd0, if0.rx_busy}, 0);

    // T2 short glitch rejected
    rx0 = 1'b0;
    repeat (4 * TICK_CLKS) @(negedge clk);
    chk("t2_busy_hi", {31'd0, if0.rx_busy}, 1);
    rx0 = 1'b1;
    c = 0;
    while (if0.rx_busy && c < 10 * TICK_CLKS) begin
      @(negedge clk);
      c++;
    end
    chk("t2_busy_lo", {31'd0, if0.rx_busy}, 0);
    drive_bit(0, 1'b1);
    chk("t2_nvalid", nv0, 5);
    chk("t2_nerr", nfe0 + noe0, 0);

    // T3 stop bit low, line held low (break)
    send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (40 * TICK_CLKS) @(negedge clk);
    chk("t3_fe", nfe0, 1);
    chk("t3_nvalid", nv0, 5);
    chk("t3_in_break", {31'd0, if0.rx_busy}, 1);
    chk("t3_data_hold", {24'd0, if0.rx_data}, 0);
    drive_bit(0, 1'b1);
    chk("t3_idle", {31'd0, if0.rx_busy}, 0);
    q0.push_back('{d: 8'h3C, pe: 1'b0});
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    chk("t3_nvalid2", nv0, 6);
    chk("t3_fe2", nfe0, 1);

    // T5 overrun on full FIFO
    if0.fifo_full = 1'b1;
    send(0, 8'h81, 1'b0, 1'b0, 1'b1);
    if0.fifo_full = 1'b0;
    chk("t5_oe", noe0, 1);
    chk("t5_nvalid", nv0, 6);
    chk("t5_data_hold", {24'd0, if0.rx_data}, 32'h3C);

    // T6 reset mid-DATA
    v0 = nv0; fe0 = nfe0; oe0 = noe0;
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    chk("t6_busy_pre", {31'd0, if0.rx_busy}, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, if0.rx_busy}, 0);
    chk("t6_rst_data", {24'd0, if0.rx_data}, 0);
    rx0 = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    chk("t6_no_pulse", (nv0 - v0) + (nfe0 - fe0) + (noe0 - oe0), 0);
    q0.push_back('{d: 8'h96, pe: 1'b0});
    send(0, 8'h96, 1'b0, 1'b0, 1'b1);
    chk("t6_nvalid", nv0, v0 + 1);
    chk("t6_data", {24'd0, if0.rx_data}, 32'h96);

    // T4 even parity on second instance
    q1.push_back('{d: 8'h07, pe: 1'b1});
    send(1, 8'h07, 1'b1, 1'b0, 1'b1);
    q1.push_back('{d: 8'h07, pe: 1'b0});
    send(1, 8'h07, 1'b1, 1'b1, 1'b1);
    chk("t4_nvalid", nv1, 2);
    chk("t4_npe", npe1, 1);
    chk("t4_other", nfe1 + noe1, 0);
    chk("t4_q_empty", q1.size(), 0);
    chk("end_q0_empty", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
